// File: rtl/load_pkg.sv
// Shared definitions for the RV32I load unit: funct3 codes, FSM states and
// the access-legality predicate used when a load is accepted.
package load_pkg;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_REQ   = 2'd1,
    S_DONE  = 2'd2,
    S_FAULT = 2'd3
  } state_t;

  // True when the load must fault: illegal funct3 or misaligned address.
  function automatic logic access_fault(input logic [2:0] f3, input logic [1:0] a);
    logic r;
    case (f3)
      F3_LB, F3_LBU: r = 1'b0;
      F3_LH, F3_LHU: r = a[0];
      F3_LW:         r = (a != 2'b00);
      default:       r = 1'b1;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/load_extend.sv
// Selects the addressed byte/half/word from a memory word and sign- or
// zero-extends it to 32 bits.
module load_extend
  import load_pkg::*;
(
  input  logic [31:0] i_rdata,
  input  logic [2:0]  i_funct3,
  input  logic [1:0]  i_lane,
  output logic [31:0] o_data
);

  logic [7:0]  w_b;
  logic [15:0] w_h;

  always_comb begin
    w_b    = i_rdata[{i_lane, 3'b000} +: 8];
    w_h    = i_rdata[{i_lane[1], 4'b0000} +: 16];
    o_data = i_rdata;
    case (i_funct3)
      F3_LB:   o_data = {{24{w_b[7]}}, w_b};
      F3_LBU:  o_data = {24'h0, w_b};
      F3_LH:   o_data = {{16{w_h[15]}}, w_h};
      F3_LHU:  o_data = {16'h0, w_h};
      default: o_data = i_rdata;
    endcase
  end

endmodule

// File: rtl/load_unit.sv
// RV32I load unit: word-aligned read over req/ack, then byte/half/word
// extraction with a one-cycle done (and err on fault/timeout) pulse.
module load_unit
  import load_pkg::*;
#(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rs_i,
  input  logic        start_i,
  input  logic [2:0]  funct3_i,
  input  logic [31:0] addr_i,
  output logic        mem_req_o,
  output logic [31:0] mem_addr_o,
  input  logic        mem_ack_i,
  input  logic [31:0] mem_rdata_i,
  output logic        busy_o,
  output logic        done_o,
  output logic        err_o,
  output logic [31:0] data_o
);

  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] LAST = CW'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

  state_t        r_state, w_next;
  logic [2:0]    r_f3;
  logic [31:0]   r_addr;
  logic [31:0]   r_data;
  logic [CW-1:0] r_cnt;
  logic [31:0]   w_ext;
  logic          w_timeout;

  load_extend u_ext (
    .i_rdata  (mem_rdata_i),
    .i_funct3 (r_f3),
    .i_lane   (r_addr[1:0]),
    .o_data   (w_ext)
  );

  // r_cnt counts REQ cycles already spent without ack; LAST is the final one.
  assign w_timeout  = (TIMEOUT != 0) && (r_cnt == LAST);
  assign mem_addr_o = {r_addr[31:2], 2'b00};
  assign data_o     = r_data;

  always_ff @(posedge clk or posedge rs_i) begin
    if (rs_i) r_state <= S_IDLE;
    else      r_state <= w_next;
  end

  always_comb begin
    w_next    = r_state;
    mem_req_o = 1'b0;
    busy_o    = 1'b1;
    done_o    = 1'b0;
    err_o     = 1'b0;
    case (r_state)
      S_IDLE: begin
        busy_o = 1'b0;
        if (start_i) w_next = access_fault(funct3_i, addr_i[1:0]) ? S_FAULT : S_REQ;
      end
      S_REQ: begin
        mem_req_o = 1'b1;
        if (mem_ack_i)      w_next = S_DONE;
        else if (w_timeout) w_next = S_FAULT;
      end
      S_DONE: begin
        done_o = 1'b1;
        w_next = S_IDLE;
      end
      S_FAULT: begin
        done_o = 1'b1;
        err_o  = 1'b1;
        w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rs_i) begin
    if (rs_i) begin
      r_f3   <= 3'b000;
      r_addr <= 32'h0;
      r_data <= 32'h0;
      r_cnt  <= '0;
    end else begin
      if (r_state == S_IDLE && start_i) begin
        r_f3   <= funct3_i;
        r_addr <= addr_i;
      end
      if (r_state == S_REQ && !mem_ack_i) r_cnt <= r_cnt + 1'b1;
      else                                r_cnt <= '0;
      if (r_state == S_REQ && mem_ack_i) r_data <= w_ext;
    end
  end

endmodule

// File: tb/tb_load_unit.sv
// Scoreboard bench for load_unit: stimulus pushes expected results, a
// monitor pops and compares on every done_o pulse.
module tb_load_unit;

  localparam int unsigned TO = 8;

  typedef struct packed {
    logic [31:0] data;
    logic        err;
  } exp_t;

  logic        clk = 1'b0;
  logic        rs_i;
  logic        start_i;
  logic [2:0]  funct3_i;
  logic [31:0] addr_i;
  logic        mem_req_o;
  logic [31:0] mem_addr_o;
  logic        mem_ack_i;
  logic [31:0] mem_rdata_i;
  logic        busy_o, done_o, err_o;
  logic [31:0] data_o;

  int   pass_cnt = 0;
  int   total_cnt = 0;
  exp_t exp_q[$];
  logic [31:0] model_data = 32'h0;

  load_unit #(.TIMEOUT(TO)) dut (
    .clk(clk), .rs_i(rs_i), .start_i(start_i), .funct3_i(funct3_i), .addr_i(addr_i),
    .mem_req_o(mem_req_o), .mem_addr_o(mem_addr_o), .mem_ack_i(mem_ack_i),
    .mem_rdata_i(mem_rdata_i), .busy_o(busy_o), .done_o(done_o), .err_o(err_o),
    .data_o(data_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  // Reference: size/sign from funct3, value by shifting and masking the word.
  function automatic void ref_load(input logic [2:0] f3, input logic [31:0] a,
                                   input logic [31:0] rd, output exp_t e, output bit flt);
    int unsigned sz;
    logic [31:0] v, mask;
    sz  = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
    flt = (f3 == 3'd3) || (f3 == 3'd6) || (f3 == 3'd7) || ((a % sz) != 0);
    if (flt) begin
      e.data = model_data;
      e.err  = 1'b1;
    end else begin
      v = rd >> (8 * (a % 4));
      if (sz < 4) begin
        mask = (32'd1 << (8 * sz)) - 32'd1;
        v = v & mask;
        if (!f3[2] && v[8*sz-1]) v = v | ~mask;
      end
      e.data = v;
      e.err  = 1'b0;
    end
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (!rs_i && done_o) begin
      if (exp_q.size() == 0) begin
        total_cnt++;
        $display("FAIL unexpected_done: got data 0x%08h err %0b with nothing expected", data_o, err_o);
      end else begin
        e = exp_q.pop_front();
        check("done_data", data_o, e.data);
        check("done_err", {31'h0, err_o}, {31'h0, e.err});
      end
    end
  end

  task automatic do_load(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] rd,
                         input int dly, input bit no_ack, input bit extra);
    exp_t e;
    bit   flt;
    int   n;
    ref_load(f3, a, rd, e, flt);
    if (no_ack && !flt) begin
      e.data = model_data;
      e.err  = 1'b1;
    end
    @(negedge clk);
    start_i = 1'b1; funct3_i = f3; addr_i = a;
    exp_q.push_back(e);
    @(negedge clk);
    start_i = 1'b0; funct3_i = 3'($urandom); addr_i = $urandom;
    if (flt) begin
      check("fault_no_req", {31'h0, mem_req_o}, 32'h0);
      check("fault_done", {31'h0, done_o}, 32'h1);
      check("fault_err", {31'h0, err_o}, 32'h1);
    end else begin
      n = 0;
      while (mem_req_o && n < 64) begin
        n++;
        check("addr_stable", mem_addr_o, {a[31:2], 2'b00});
        if (!no_ack && n == dly + 1) begin
          mem_ack_i = 1'b1; mem_rdata_i = rd;
        end
        if (extra && n == 2) start_i = 1'b1;
        @(negedge clk);
        mem_ack_i = 1'b0; start_i = 1'b0; mem_rdata_i = $urandom;
      end
      check("req_cycles", n, no_ack ? TO : dly + 1);
      check("done_pulse", {31'h0, done_o}, 32'h1);
      check("err_flag", {31'h0, err_o}, {31'h0, no_ack});
    end
    model_data = e.data;
    @(negedge clk);
    check("done_single", {31'h0, done_o}, 32'h0);
    check("idle_after", {31'h0, busy_o}, 32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rs_i = 1'b1; start_i = 1'b0; funct3_i = 3'b0; addr_i = 32'h0;
    mem_ack_i = 1'b0; mem_rdata_i = 32'h0;
    #1;
    check("rst_req", {31'h0, mem_req_o}, 32'h0);
    check("rst_addr", mem_addr_o, 32'h0);
    check("rst_busy", {31'h0, busy_o}, 32'h0);
    check("rst_done", {31'h0, done_o}, 32'h0);
    check("rst_err", {31'h0, err_o}, 32'h0);
    check("rst_data", data_o, 32'h0);
    repeat (2) @(negedge clk);
    rs_i = 1'b0;

    // Extraction with prompt ack
    do_load(3'b000, 32'h103, 32'h8086F0A5, 0, 0, 0);
    check("lb_addr", mem_addr_o, 32'h100);
    do_load(3'b100, 32'h101, 32'h8086F0A5, 0, 0, 0);
    do_load(3'b001, 32'h102, 32'h8086F0A5, 0, 0, 0);
    do_load(3'b101, 32'h100, 32'h8086F0A5, 0, 0, 0);
    do_load(3'b000, 32'h100, 32'h8086F0A5, 0, 0, 0);

    // Delayed ack with an ignored start during REQ
    do_load(3'b010, 32'h200, 32'h12345678, 3, 0, 1);
    check("lw_data", data_o, 32'h12345678);

    // Faults leave data_o untouched
    do_load(3'b101, 32'h0, 32'h5555ABCD, 1, 0, 0);
    do_load(3'b010, 32'h202, 32'hDEADBEEF, 0, 0, 0);
    do_load(3'b001, 32'h101, 32'hDEADBEEF, 0, 0, 0);
    do_load(3'b011, 32'h100, 32'hDEADBEEF, 0, 0, 0);
    check("fault_keep", data_o, 32'h0000ABCD);

    // ack outside REQ is ignored
    @(negedge clk); mem_ack_i = 1'b1; mem_rdata_i = 32'hFFFFFFFF;
    @(negedge clk); mem_ack_i = 1'b0;
    check("stray_ack", data_o, 32'h0000ABCD);

    // Timeout then a normal load
    do_load(3'b010, 32'h400, 32'h0, 0, 1, 0);
    do_load(3'b010, 32'h404, 32'hCAFEF00D, 0, 0, 0);

    // Randomized loads
    for (int i = 0; i < 40; i++)
      do_load(3'($urandom_range(0, 7)), $urandom, $urandom, $urandom_range(0, 4), 0, 0);

    // Reset between edges mid-REQ
    @(negedge clk);
    start_i = 1'b1; funct3_i = 3'b010; addr_i = 32'h300;
    @(negedge clk);
    start_i = 1'b0;
    check("pre_rst_req", {31'h0, mem_req_o}, 32'h1);
    #2 rs_i = 1'b1;
    #1;
    check("async_req", {31'h0, mem_req_o}, 32'h0);
    check("async_busy", {31'h0, busy_o}, 32'h0);
    check("async_data", data_o, 32'h0);
    @(negedge clk);
    rs_i = 1'b0;
    model_data = 32'h0;
    repeat (5) @(negedge clk);
    check("post_rst_busy", {31'h0, busy_o}, 32'h0);
    do_load(3'b100, 32'h7, 32'h80FF0000, 2, 0, 0);

    repeat (2) @(negedge clk);
    check("queue_empty", exp_q.size(), 32'h0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
